usb_pe_in: RTL and testbench



---
 rtl/usb_pe_in_if.sv | 31 +++
 rtl/usb_pe_in.sv | 219 +++++++++++++++++++++
 tb/tb_usb_pe_in.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pe_in_if.sv
// usb_pe_in_if
//   Packet-level bus between the IN protocol engine and the usbRxPkt /
//   usbTxPkt pair.
//   Receive side (from usbRxPkt): rxPktEnd, rxPktValid, rxPid, rxAddr, rxEndp.
//   Transmit side (to/from usbTxPkt): txPktBegin, txPid, txDataAvail, txData
//   driven by the engine; txDataGet, txPktEnd returned by the transmitter.
//   modport master : the protocol engine (drives the transmit request side).
//   modport slave  : the packet layer (drives received fields and tx handshakes).
interface usb_pe_in_if;
    logic       rxPktEnd;
    logic       rxPktValid;
    logic [3:0] rxPid;
    logic [6:0] rxAddr;
    logic [3:0] rxEndp;
    logic       txPktBegin;
    logic [3:0] txPid;
    logic       txDataAvail;
    logic [7:0] txData;
    logic       txDataGet;
    logic       txPktEnd;

    modport master (
        input  rxPktEnd, rxPktValid, rxPid, rxAddr, rxEndp, txDataGet, txPktEnd,
        output txPktBegin, txPid, txDataAvail, txData
    );

    modport slave (
        output rxPktEnd, rxPktValid, rxPid, rxAddr, rxEndp, txDataGet, txPktEnd,
        input  txPktBegin, txPid, txDataAvail, txData
    );
endinterface

// File: rtl/usb_pe_in.sv
// usb_pe_in
//   IN protocol engine. Each IN endpoint owns a packet buffer filled by its
//   endpoint controller; addressed IN tokens are answered with DATA0/DATA1,
//   NAK or STALL, and a sent packet is retired only when the host ACKs it.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_devAddr           : assigned device address
//   i_inEp_dataPut/Data : per-endpoint byte write strobe and the shared byte
//   i_inEp_dataDone     : commit the buffered bytes as one packet
//   i_inEp_stall        : endpoint halted
//   o_inEp_free         : endpoint is filling and has room
//   o_inEp_acked        : one-cycle pulse when the host ACKs that endpoint
//   bus                 : packet-layer interface (master side)
module usb_pe_in #(
    parameter int N_EP_IN            = 1,
    parameter int MAX_IN_PACKET_SIZE = 8,
    parameter int ACK_TIMEOUT        = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [6:0]         i_devAddr,
    input  logic [N_EP_IN-1:0] i_inEp_dataPut,
    input  logic [7:0]         i_inEp_data,
    input  logic [N_EP_IN-1:0] i_inEp_dataDone,
    input  logic [N_EP_IN-1:0] i_inEp_stall,
    output logic [N_EP_IN-1:0] o_inEp_free,
    output logic [N_EP_IN-1:0] o_inEp_acked,
    usb_pe_in_if.master        bus
);
    localparam int PTR_W = $clog2(MAX_IN_PACKET_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int EP_W  = (N_EP_IN > 1) ? $clog2(N_EP_IN) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_IN_PACKET_SIZE);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT);

    localparam logic [3:0] PID_TOKEN_IN        = 4'b1001;
    localparam logic [3:0] PID_TOKEN_SETUP     = 4'b1101;
    localparam logic [3:0] PID_DATA0           = 4'b0011;
    localparam logic [3:0] PID_DATA1           = 4'b1011;
    localparam logic [3:0] PID_HANDSHAKE_ACK   = 4'b0010;
    localparam logic [3:0] PID_HANDSHAKE_NAK   = 4'b1010;
    localparam logic [3:0] PID_HANDSHAKE_STALL = 4'b1110;

    typedef enum logic [1:0] {EP_FILLING, EP_READY, EP_SENDING} epState_t;
    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_RESPOND  = 5'b00010,
        ST_DATA_TX  = 5'b00100,
        ST_ACK_WAIT = 5'b01000,
        ST_HS_WAIT  = 5'b10000
    } xferState_t;

    epState_t         epState [N_EP_IN];
    logic [CNT_W-1:0] putCnt  [N_EP_IN];
    logic [N_EP_IN-1:0] toggle;
    logic [7:0]       buffer  [N_EP_IN*MAX_IN_PACKET_SIZE];

    xferState_t       state, stateNext;
    logic [EP_W-1:0]  curEp;
    logic [CNT_W-1:0] getAddr;
    logic [TMR_W-1:0] timer;
    logic [3:0]       txPidReg;
    logic [3:0]       respPid;
    logic             selectData, ackOk, rollback;

    logic             tokHit, inTok, setupTok;
    logic [EP_W-1:0]  tokEp;
    logic             putHit;
    logic [EP_W-1:0]  putEp;
    logic [N_EP_IN-1:0] putAccept;

    // Tokens are only decoded while idle; anything arriving mid-transfer is dropped.
    assign tokHit   = bus.rxPktEnd && bus.rxPktValid && (bus.rxAddr == i_devAddr)
                      && (int'(bus.rxEndp) < N_EP_IN) && (state == ST_IDLE);
    assign inTok    = tokHit && (bus.rxPid == PID_TOKEN_IN);
    assign setupTok = tokHit && (bus.rxPid == PID_TOKEN_SETUP);
    assign tokEp    = bus.rxEndp[EP_W-1:0];

    // The buffer has a single write port, so simultaneous puts resolve to the
    // lowest-numbered endpoint; the others are dropped entirely.
    always_comb begin
        putHit    = 1'b0;
        putEp     = '0;
        putAccept = '0;
        for (int e = N_EP_IN - 1; e >= 0; e--) begin
            if (i_inEp_dataPut[e]) begin
                putHit = 1'b1;
                putEp  = EP_W'(e);
            end
        end
        for (int e = 0; e < N_EP_IN; e++) begin
            o_inEp_free[e] = (epState[e] == EP_FILLING) && (putCnt[e] < MAX_CNT);
            putAccept[e]   = putHit && (putEp == EP_W'(e)) && o_inEp_free[e];
        end
    end

    // Buffer contents need no reset: clearing putCnt already discards them.
    always_ff @(posedge i_clk) begin
        if (|putAccept) begin
            buffer[{putEp, putCnt[putEp][PTR_W-1:0]}] <= i_inEp_data;
        end
    end

    // Per-endpoint FILLING -> READY -> SENDING cycle; a failed delivery drops
    // back to READY so the identical packet and toggle are offered again.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int e = 0; e < N_EP_IN; e++) begin
                epState[e] <= EP_FILLING;
                putCnt[e]  <= '0;
            end
            toggle       <= '0;
            o_inEp_acked <= '0;
        end else begin
            o_inEp_acked <= '0;
            for (int e = 0; e < N_EP_IN; e++) begin
                case (epState[e])
                    EP_FILLING: begin
                        if (putAccept[e]) putCnt[e] <= putCnt[e] + CNT_W'(1);
                        if (i_inEp_dataDone[e]) epState[e] <= EP_READY;
                    end
                    EP_READY: begin
                        if (selectData && (curEp == EP_W'(e))) epState[e] <= EP_SENDING;
                    end
                    EP_SENDING: begin
                        if (ackOk) begin
                            epState[e]      <= EP_FILLING;
                            putCnt[e]       <= '0;
                            toggle[e]       <= ~toggle[e];
                            o_inEp_acked[e] <= 1'b1;
                        end else if (rollback) begin
                            epState[e] <= EP_READY;
                        end
                    end
                    default: epState[e] <= EP_FILLING;
                endcase
                if (setupTok && (tokEp == EP_W'(e))) toggle[e] <= 1'b1;
            end
        end
    end

    // Transfer state register plus the datapath registers it steers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            curEp    <= '0;
            getAddr  <= '0;
            timer    <= '0;
            txPidReg <= '0;
        end else begin
            state <= stateNext;
            if (inTok) curEp <= tokEp;
            if (state == ST_RESPOND) begin
                txPidReg <= respPid;
                getAddr  <= '0;
            end
            if ((state == ST_DATA_TX) && bus.txDataGet && bus.txDataAvail) begin
                getAddr <= getAddr + CNT_W'(1);
            end
            if ((state == ST_DATA_TX) && bus.txPktEnd) begin
                timer <= '0;
            end else if (state == ST_ACK_WAIT) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // Next-state and transmit outputs. txPid is shown live during the begin
    // strobe and held from txPidReg afterwards.
    always_comb begin
        stateNext       = state;
        bus.txPktBegin  = 1'b0;
        bus.txPid       = txPidReg;
        bus.txDataAvail = 1'b0;
        bus.txData      = 8'h00;
        respPid         = PID_HANDSHAKE_NAK;
        selectData      = 1'b0;
        ackOk           = 1'b0;
        rollback        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inTok) stateNext = ST_RESPOND;
            end
            ST_RESPOND: begin
                bus.txPktBegin = 1'b1;
                if (i_inEp_stall[curEp]) begin
                    respPid   = PID_HANDSHAKE_STALL;
                    stateNext = ST_HS_WAIT;
                end else if (epState[curEp] == EP_READY) begin
                    respPid    = toggle[curEp] ? PID_DATA1 : PID_DATA0;
                    selectData = 1'b1;
                    stateNext  = ST_DATA_TX;
                end else begin
                    stateNext = ST_HS_WAIT;
                end
                bus.txPid = respPid;
            end
            ST_DATA_TX: begin
                bus.txDataAvail = getAddr < putCnt[curEp];
                if (bus.txDataAvail) bus.txData = buffer[{curEp, getAddr[PTR_W-1:0]}];
                if (bus.txPktEnd) stateNext = ST_ACK_WAIT;
            end
            ST_ACK_WAIT: begin
                if (bus.rxPktEnd) begin
                    if (bus.rxPktValid && (bus.rxPid == PID_HANDSHAKE_ACK)) ackOk = 1'b1;
                    else rollback = 1'b1;
                    stateNext = ST_IDLE;
                end else if (timer == TMR_MAX) begin
                    rollback  = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            ST_HS_WAIT: begin
                if (bus.txPktEnd) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_pe_in.sv
// tb_usb_pe_in
//   Self-checking bench for usb_pe_in (2 endpoints, 8-byte buffers, short
//   ACK timeout). Expected responses come from a queue-per-endpoint model of
//   the packet rules: bytes pushed while not committed, commit on done,
//   IN answered by stall / data with toggle / NAK, ACK retires and toggles.
module tb_usb_pe_in;
    localparam int NEP  = 2;
    localparam int MAXP = 8;
    localparam int TMO  = 40;
    localparam logic [6:0] DEV = 7'h2A;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_D0    = 4'b0011;
    localparam logic [3:0] PID_D1    = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NEP-1:0] dataPut = '0;
    logic [NEP-1:0] dataDone = '0;
    logic [NEP-1:0] stall = '0;
    logic [7:0]     data = '0;
    logic [NEP-1:0] free;
    logic [NEP-1:0] acked;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0] epQ [NEP][$];
    bit         committed [NEP];
    bit         tog [NEP];

    usb_pe_in_if bus ();

    usb_pe_in #(.N_EP_IN(NEP), .MAX_IN_PACKET_SIZE(MAXP), .ACK_TIMEOUT(TMO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_devAddr(DEV),
        .i_inEp_dataPut(dataPut),
        .i_inEp_data(data),
        .i_inEp_dataDone(dataDone),
        .i_inEp_stall(stall),
        .o_inEp_free(free),
        .o_inEp_acked(acked),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NEP-1:0] modelFree();
        logic [NEP-1:0] r;
        for (int e = 0; e < NEP; e++) r[e] = !committed[e] && (epQ[e].size() < MAXP);
        return r;
    endfunction

    function automatic void modelReset();
        for (int e = 0; e < NEP; e++) begin
            epQ[e].delete();
            committed[e] = 1'b0;
            tog[e]       = 1'b0;
        end
    endfunction

    // One cycle of endpoint-controller activity: optional put and/or commit.
    task automatic applyStimulus(input logic [NEP-1:0] mask, input logic [7:0] val, input logic [NEP-1:0] done);
        dataPut  = mask;
        data     = val;
        dataDone = done;
        tick();
        dataPut  = '0;
        dataDone = '0;
        for (int e = 0; e < NEP; e++) begin
            if (mask[e]) begin
                if (!committed[e] && epQ[e].size() < MAXP) epQ[e].push_back(val);
                break;
            end
        end
        for (int e = 0; e < NEP; e++) if (done[e]) committed[e] = 1'b1;
        checkOutput("free", {{(32-NEP){1'b0}}, free}, {{(32-NEP){1'b0}}, modelFree()});
    endtask

    task automatic sendPkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp, input logic valid);
        bus.rxPktEnd   = 1'b1;
        bus.rxPktValid = valid;
        bus.rxPid      = pid;
        bus.rxAddr     = addr;
        bus.rxEndp     = endp;
        tick();
        bus.rxPktEnd   = 1'b0;
        bus.rxPktValid = 1'b0;
    endtask

    task automatic expectSilent(input string tag);
        checkOutput(tag, {31'd0, bus.txPktBegin}, 32'd0);
        tick();
        checkOutput(tag, {31'd0, bus.txPktBegin}, 32'd0);
    endtask

    // Full IN transaction. kind: 0 = host ACKs, 1 = host stays silent,
    // 2 = host sends something other than a valid ACK.
    task automatic inTransfer(input int ep, input int kind);
        logic [3:0]     expPid;
        logic [NEP-1:0] expAck;
        logic           bogusValid;
        expAck = '0;
        expAck[ep] = 1'b1;
        if (stall[ep])          expPid = PID_STALL;
        else if (committed[ep]) expPid = tog[ep] ? PID_D1 : PID_D0;
        else                    expPid = PID_NAK;
        sendPkt(PID_IN, DEV, 4'(ep), 1'b1);
        checkOutput("txPktBegin", {31'd0, bus.txPktBegin}, 32'd1);
        checkOutput("txPid", {28'd0, bus.txPid}, {28'd0, expPid});
        tick();
        checkOutput("beginOneCycle", {31'd0, bus.txPktBegin}, 32'd0);
        checkOutput("pidHold", {28'd0, bus.txPid}, {28'd0, expPid});
        if (expPid == PID_NAK || expPid == PID_STALL) begin
            bus.txPktEnd = 1'b1;
            tick();
            bus.txPktEnd = 1'b0;
        end else begin
            for (int i = 0; i < epQ[ep].size(); i++) begin
                checkOutput("txDataAvail", {31'd0, bus.txDataAvail}, 32'd1);
                checkOutput("txData", {24'd0, bus.txData}, {24'd0, epQ[ep][i]});
                bus.txDataGet = 1'b1;
                tick();
                bus.txDataGet = 1'b0;
            end
            checkOutput("availEnd", {31'd0, bus.txDataAvail}, 32'd0);
            bus.txDataGet = 1'b1;
            tick();
            bus.txDataGet = 1'b0;
            checkOutput("availExtraGet", {31'd0, bus.txDataAvail}, 32'd0);
            bus.txPktEnd = 1'b1;
            tick();
            bus.txPktEnd = 1'b0;
            if (kind == 0) begin
                sendPkt(PID_ACK, 7'd0, 4'd0, 1'b1);
                checkOutput("ackedPulse", {{(32-NEP){1'b0}}, acked}, {{(32-NEP){1'b0}}, expAck});
                epQ[ep].delete();
                committed[ep] = 1'b0;
                tog[ep] = ~tog[ep];
                tick();
                checkOutput("ackedLow", {{(32-NEP){1'b0}}, acked}, 32'd0);
                checkOutput("freeAfterAck", {{(32-NEP){1'b0}}, free}, {{(32-NEP){1'b0}}, modelFree()});
            end else if (kind == 1) begin
                repeat (TMO + 3) tick();
                checkOutput("noAckTimeout", {{(32-NEP){1'b0}}, acked}, 32'd0);
            end else begin
                bogusValid = 1'($urandom_range(0, 1));
                sendPkt(bogusValid ? PID_NAK : PID_ACK, 7'd0, 4'd0, bogusValid);
                checkOutput("noAckBogus", {{(32-NEP){1'b0}}, acked}, 32'd0);
                tick();
            end
        end
    endtask

    initial begin
        int n;
        int ep;
        int kind;
        bus.rxPktEnd = 1'b0;
        bus.rxPktValid = 1'b0;
        bus.rxPid = '0;
        bus.rxAddr = '0;
        bus.rxEndp = '0;
        bus.txDataGet = 1'b0;
        bus.txPktEnd = 1'b0;
        modelReset();

        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("rstBegin", {31'd0, bus.txPktBegin}, 32'd0);
        checkOutput("rstPid", {28'd0, bus.txPid}, 32'd0);
        checkOutput("rstAvail", {31'd0, bus.txDataAvail}, 32'd0);
        checkOutput("rstAcked", {{(32-NEP){1'b0}}, acked}, 32'd0);
        checkOutput("rstFree", {{(32-NEP){1'b0}}, free}, 32'd3);

        $display("[TB] basic EP0 packet");
        applyStimulus(2'b01, 8'h11, 2'b00);
        applyStimulus(2'b01, 8'h22, 2'b00);
        applyStimulus(2'b01, 8'h33, 2'b00);
        applyStimulus(2'b00, 8'h00, 2'b01);
        inTransfer(0, 0);

        $display("[TB] NAK on empty endpoint");
        inTransfer(1, 0);
        checkOutput("nakFree", {{(32-NEP){1'b0}}, free}, {{(32-NEP){1'b0}}, modelFree()});

        $display("[TB] timeout then retry");
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 8'($urandom_range(0, 255)), 2'b00);
        applyStimulus(2'b00, 8'h00, 2'b01);
        inTransfer(0, 1);
        inTransfer(0, 0);

        $display("[TB] overfill and zero-length packet");
        for (int i = 0; i < 9; i++) applyStimulus(2'b10, 8'(8'hA0 + i), 2'b00);
        applyStimulus(2'b00, 8'h00, 2'b10);
        inTransfer(1, 0);
        applyStimulus(2'b00, 8'h00, 2'b10);
        inTransfer(1, 0);

        $display("[TB] put with done, simultaneous puts");
        applyStimulus(2'b01, 8'h5A, 2'b00);
        applyStimulus(2'b01, 8'hC3, 2'b01);
        inTransfer(0, 0);
        applyStimulus(2'b11, 8'h77, 2'b00);
        applyStimulus(2'b11, 8'h88, 2'b11);
        inTransfer(0, 0);
        inTransfer(1, 0);

        $display("[TB] setup, stall, ignored tokens");
        sendPkt(PID_SETUP, DEV, 4'd0, 1'b1);
        tog[0] = 1'b1;
        expectSilent("setupSilent");
        applyStimulus(2'b01, 8'h9E, 2'b01);
        stall[0] = 1'b1;
        inTransfer(0, 0);
        stall[0] = 1'b0;
        sendPkt(PID_IN, DEV ^ 7'h01, 4'd0, 1'b1);
        expectSilent("wrongAddr");
        sendPkt(PID_IN, DEV, 4'd0, 1'b0);
        expectSilent("badCrc");
        sendPkt(PID_IN, DEV, 4'd3, 1'b1);
        expectSilent("badEndp");
        inTransfer(0, 0);

        $display("[TB] randomized transfers");
        for (int r = 0; r < 10; r++) begin
            ep = $urandom_range(0, NEP - 1);
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                applyStimulus(NEP'(1 << ep), 8'($urandom_range(0, 255)),
                              (i == n - 1 && $urandom_range(0, 1) == 1) ? NEP'(1 << ep) : NEP'(0));
            end
            if (!committed[ep]) applyStimulus('0, 8'h00, NEP'(1 << ep));
            inTransfer(1 - ep, 0);
            kind = $urandom_range(0, 2);
            inTransfer(ep, kind);
            if (kind != 0) inTransfer(ep, 0);
        end

        $display("[TB] reset during data transfer");
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 8'($urandom_range(0, 255)), 2'b00);
        applyStimulus(2'b00, 8'h00, 2'b01);
        sendPkt(PID_IN, DEV, 4'd0, 1'b1);
        tick();
        bus.txDataGet = 1'b1;
        tick();
        bus.txDataGet = 1'b0;
        checkOutput("availBeforeReset", {31'd0, bus.txDataAvail}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstBegin", {31'd0, bus.txPktBegin}, 32'd0);
        checkOutput("midRstPid", {28'd0, bus.txPid}, 32'd0);
        checkOutput("midRstAvail", {31'd0, bus.txDataAvail}, 32'd0);
        checkOutput("midRstAcked", {{(32-NEP){1'b0}}, acked}, 32'd0);
        checkOutput("midRstFree", {{(32-NEP){1'b0}}, free}, 32'd3);
        tick();
        rst = 1'b0;
        modelReset();
        tick();
        inTransfer(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
